// File: rtl/cpu_controller_if.sv
// Control bus between the multi-cycle controller and the 16-bit datapath.
// The controller side (master) drives every select/enable; the datapath side returns the instruction word.
interface cpu_controller_if #(
    parameter int PC_W = 7,
    parameter int DA_W = 8,
    parameter int RA_W = 4
);
    logic [15:0]     IR_in;
    logic [PC_W-1:0] PC_addr;
    logic            IR_ld;
    logic [DA_W-1:0] D_addr;
    logic            D_wr;
    logic            RF_s;
    logic [RA_W-1:0] RF_W_addr;
    logic            RF_W_en;
    logic [RA_W-1:0] RF_Ra_addr;
    logic [RA_W-1:0] RF_Rb_addr;
    logic [2:0]      ALU_sel;
    logic            Halted;
    logic [3:0]      State;

    modport master (
        input  IR_in,
        output PC_addr, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, ALU_sel, Halted, State
    );

    modport slave (
        output IR_in,
        input  PC_addr, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, ALU_sel, Halted, State
    );
endinterface

// File: rtl/cpu_controller.sv
// Multi-cycle control unit: fetch, decode and sequence one instruction at a time.
// All outputs are Moore-decoded from the registered state and instruction register.
module cpu_controller #(
    parameter int PC_W = 7,
    parameter int DA_W = 8,
    parameter int RA_W = 4
) (
    input  logic Clk,
    input  logic ResetN,
    cpu_controller_if.master bus
);

    typedef enum logic [3:0] {
        INIT   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        LOAD_A = 4'd3,
        LOAD_B = 4'd4,
        STORE  = 4'd5,
        ALU_OP = 4'd6,
        NOOP   = 4'd7,
        HALT   = 4'd8
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [PC_W-1:0] pc;
    logic [15:0]     ir;
    logic [3:0]      op;
    logic [3:0]      alu_code;

    assign op       = ir[15:12];
    // ALU opcodes 0011..1001 map onto selects 1..7, so the select is simply op-2
    assign alu_code = op - 4'd2;

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state <= INIT;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= next_state;
            if (state == FETCH) begin
                ir <= bus.IR_in;
                pc <= pc + 1'b1;
            end
        end
    end

    always_comb begin
        next_state     = state;
        bus.IR_ld      = 1'b0;
        bus.D_addr     = '0;
        bus.D_wr       = 1'b0;
        bus.RF_s       = 1'b0;
        bus.RF_W_addr  = '0;
        bus.RF_W_en    = 1'b0;
        bus.RF_Ra_addr = '0;
        bus.RF_Rb_addr = '0;
        bus.ALU_sel    = 3'd0;
        bus.Halted     = 1'b0;

        case (state)
            INIT: begin
                next_state = FETCH;
            end
            FETCH: begin
                bus.IR_ld  = 1'b1;
                next_state = DECODE;
            end
            DECODE: begin
                case (op)
                    4'b0001: next_state = STORE;
                    4'b0010: next_state = LOAD_A;
                    4'b0011, 4'b0100, 4'b0101, 4'b0110,
                    4'b0111, 4'b1000, 4'b1001: next_state = ALU_OP;
                    4'b1010: next_state = HALT;
                    default: next_state = NOOP;
                endcase
            end
            LOAD_A: begin
                bus.D_addr = DA_W'(ir[11:4]);
                bus.RF_s   = 1'b1;
                next_state = LOAD_B;
            end
            LOAD_B: begin
                bus.D_addr    = DA_W'(ir[11:4]);
                bus.RF_s      = 1'b1;
                bus.RF_W_addr = RA_W'(ir[3:0]);
                bus.RF_W_en   = 1'b1;
                next_state    = FETCH;
            end
            STORE: begin
                bus.D_addr     = DA_W'(ir[7:0]);
                bus.RF_Ra_addr = RA_W'(ir[11:8]);
                bus.D_wr       = 1'b1;
                next_state     = FETCH;
            end
            ALU_OP: begin
                bus.RF_Ra_addr = RA_W'(ir[11:8]);
                bus.RF_Rb_addr = RA_W'(ir[7:4]);
                bus.ALU_sel    = alu_code[2:0];
                bus.RF_W_addr  = RA_W'(ir[3:0]);
                bus.RF_W_en    = 1'b1;
                next_state     = FETCH;
            end
            NOOP: begin
                next_state = FETCH;
            end
            HALT: begin
                bus.Halted = 1'b1;
                next_state = HALT;
            end
            default: begin
                next_state = INIT;
            end
        endcase
    end

    assign bus.PC_addr = pc;
    assign bus.State   = state;

endmodule

// File: tb/tb_cpu_controller.sv
// Directed table-driven bench for cpu_controller with a small instruction memory model.
// Each instruction's per-cycle output bundle is compared against hand-computed expectations.
module tb_cpu_controller;

    localparam logic [3:0] ST_INIT   = 4'd0;
    localparam logic [3:0] ST_FETCH  = 4'd1;
    localparam logic [3:0] ST_DECODE = 4'd2;
    localparam logic [3:0] ST_LOAD_A = 4'd3;
    localparam logic [3:0] ST_LOAD_B = 4'd4;
    localparam logic [3:0] ST_STORE  = 4'd5;
    localparam logic [3:0] ST_ALU    = 4'd6;
    localparam logic [3:0] ST_NOOP   = 4'd7;
    localparam logic [3:0] ST_HALT   = 4'd8;
    localparam int NUM_VECS = 17;

    typedef struct packed {
        logic       ir_ld;
        logic [7:0] d_addr;
        logic       d_wr;
        logic       rf_s;
        logic [3:0] w_addr;
        logic       w_en;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [2:0] alu_sel;
        logic       halted;
        logic [3:0] state;
    } out_t;

    typedef struct {
        logic [15:0] ir;
        logic        two_cycle;
        out_t        exp1;
        out_t        exp2;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic [15:0] imem [128];
    vec_t        vecs [NUM_VECS];
    int          checks;
    int          fails;

    cpu_controller_if #(.PC_W(7), .DA_W(8), .RA_W(4)) bus ();

    cpu_controller #(.PC_W(7), .DA_W(8), .RA_W(4)) dut (
        .Clk    (clk),
        .ResetN (reset_n),
        .bus    (bus)
    );

    assign bus.IR_in = imem[bus.PC_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t mk(input logic [3:0] st, input logic [7:0] d, input logic wr,
                                input logic s, input logic [3:0] wa, input logic we,
                                input logic [3:0] ra, input logic [3:0] rb, input logic [2:0] sel);
        out_t o;
        o.ir_ld   = (st == ST_FETCH);
        o.d_addr  = d;
        o.d_wr    = wr;
        o.rf_s    = s;
        o.w_addr  = wa;
        o.w_en    = we;
        o.ra      = ra;
        o.rb      = rb;
        o.alu_sel = sel;
        o.halted  = (st == ST_HALT);
        o.state   = st;
        return o;
    endfunction

    function automatic out_t sample_outputs();
        out_t o;
        o.ir_ld   = bus.IR_ld;
        o.d_addr  = bus.D_addr;
        o.d_wr    = bus.D_wr;
        o.rf_s    = bus.RF_s;
        o.w_addr  = bus.RF_W_addr;
        o.w_en    = bus.RF_W_en;
        o.ra      = bus.RF_Ra_addr;
        o.rb      = bus.RF_Rb_addr;
        o.alu_sel = bus.ALU_sel;
        o.halted  = bus.Halted;
        o.state   = bus.State;
        return o;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_output(input string name, input out_t exp);
        out_t act;
        act = sample_outputs();
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_pc(input string name, input logic [6:0] exp);
        checks++;
        if (bus.PC_addr !== exp) begin
            fails++;
            $display("[TB] FAIL %s: PC_addr got %0d, expected %0d", name, bus.PC_addr, exp);
        end
    endtask

    // Entered on the FETCH cycle of instruction idx; leaves on the following FETCH cycle
    task automatic apply_stimulus(input int idx);
        string tag;
        tag = $sformatf("vec%0d_%h", idx, vecs[idx].ir);
        check_pc({tag, "_pc"}, 7'(idx));
        check_output({tag, "_fetch"}, mk(ST_FETCH, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0));
        tick();
        check_output({tag, "_decode"}, mk(ST_DECODE, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0));
        tick();
        check_output({tag, "_exec"}, vecs[idx].exp1);
        if (vecs[idx].two_cycle) begin
            tick();
            check_output({tag, "_exec2"}, vecs[idx].exp2);
        end
        tick();
    endtask

    out_t zero_init;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks  = 0;
        fails   = 0;
        reset_n = 1'b0;
        zero_init = mk(ST_INIT, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0);
        for (int i = 0; i < 128; i++) imem[i] = 16'h0000;

        //                  ir        2cyc  exp1: state      d      wr s  wa    we ra    rb    sel
        vecs[0]  = '{16'h2053, 1'b1, mk(ST_LOAD_A, 8'h05, 0, 1, 4'h0, 0, 4'h0, 4'h0, 3'd0),
                                      mk(ST_LOAD_B, 8'h05, 0, 1, 4'h3, 1, 4'h0, 4'h0, 3'd0)};
        vecs[1]  = '{16'h3124, 1'b0, mk(ST_ALU,    8'h00, 0, 0, 4'h4, 1, 4'h1, 4'h2, 3'd1), zero_init};
        vecs[2]  = '{16'h4567, 1'b0, mk(ST_ALU,    8'h00, 0, 0, 4'h7, 1, 4'h5, 4'h6, 3'd2), zero_init};
        vecs[3]  = '{16'h5A0B, 1'b0, mk(ST_ALU,    8'h00, 0, 0, 4'hB, 1, 4'hA, 4'h0, 3'd3), zero_init};
        vecs[4]  = '{16'h6123, 1'b0, mk(ST_ALU,    8'h00, 0, 0, 4'h3, 1, 4'h1, 4'h2, 3'd4), zero_init};
        vecs[5]  = '{16'h7FED, 1'b0, mk(ST_ALU,    8'h00, 0, 0, 4'hD, 1, 4'hF, 4'hE, 3'd5), zero_init};
        vecs[6]  = '{16'h8321, 1'b0, mk(ST_ALU,    8'h00, 0, 0, 4'h1, 1, 4'h3, 4'h2, 3'd6), zero_init};
        vecs[7]  = '{16'h9404, 1'b0, mk(ST_ALU,    8'h00, 0, 0, 4'h4, 1, 4'h4, 4'h0, 3'd7), zero_init};
        vecs[8]  = '{16'h1720, 1'b0, mk(ST_STORE,  8'h20, 1, 0, 4'h0, 0, 4'h7, 4'h0, 3'd0), zero_init};
        vecs[9]  = '{16'h0000, 1'b0, mk(ST_NOOP,   8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0), zero_init};
        vecs[10] = '{16'hB123, 1'b0, mk(ST_NOOP,   8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0), zero_init};
        vecs[11] = '{16'hCFFF, 1'b0, mk(ST_NOOP,   8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0), zero_init};
        vecs[12] = '{16'hDABC, 1'b0, mk(ST_NOOP,   8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0), zero_init};
        vecs[13] = '{16'hE555, 1'b0, mk(ST_NOOP,   8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0), zero_init};
        vecs[14] = '{16'hFFFF, 1'b0, mk(ST_NOOP,   8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0), zero_init};
        vecs[15] = '{16'h1FFF, 1'b0, mk(ST_STORE,  8'hFF, 1, 0, 4'h0, 0, 4'hF, 4'h0, 3'd0), zero_init};
        vecs[16] = '{16'h2AB0, 1'b1, mk(ST_LOAD_A, 8'hAB, 0, 1, 4'h0, 0, 4'h0, 4'h0, 3'd0),
                                      mk(ST_LOAD_B, 8'hAB, 0, 1, 4'h0, 1, 4'h0, 4'h0, 3'd0)};
        for (int i = 0; i < NUM_VECS; i++) imem[i] = vecs[i].ir;

        // Reset held, then released: INIT for exactly one cycle before FETCH at PC 0
        tick();
        tick();
        check_output("reset_held", zero_init);
        check_pc("reset_pc", 7'd0);
        reset_n = 1'b1;
        check_output("init_after_release", zero_init);
        tick();

        for (int i = 0; i < NUM_VECS; i++) apply_stimulus(i);

        // Run NOOPs up to address 127, then confirm the PC wraps and fetches a HALT from 0
        imem[0] = 16'hA000;
        for (int c = 0; c < 2000; c++) begin
            if (bus.State == ST_FETCH && bus.PC_addr == 7'd127) break;
            tick();
        end
        check_pc("pc_reaches_127", 7'd127);
        check_output("fetch_127", mk(ST_FETCH, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0));
        tick();
        tick();
        check_output("noop_127", mk(ST_NOOP, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0));
        tick();
        check_pc("pc_wrap", 7'd0);
        check_output("fetch_wrap", mk(ST_FETCH, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0));
        tick();
        tick();
        for (int c = 0; c < 22; c++) begin
            check_output($sformatf("halt_c%0d", c), mk(ST_HALT, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0));
            check_pc($sformatf("halt_pc_c%0d", c), 7'd1);
            tick();
        end

        // Asynchronous reset must clear Halted without waiting for a clock edge
        reset_n = 1'b0;
        #1;
        check_output("halt_reset", zero_init);
        check_pc("halt_reset_pc", 7'd0);

        // Reset asserted during LOAD_B must drop the register-file write immediately
        imem[0] = 16'h2053;
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        tick();
        check_output("abort_load_a", mk(ST_LOAD_A, 8'h05, 0, 1, 4'h0, 0, 4'h0, 4'h0, 3'd0));
        tick();
        check_output("abort_load_b", mk(ST_LOAD_B, 8'h05, 0, 1, 4'h3, 1, 4'h0, 4'h0, 3'd0));
        reset_n = 1'b0;
        #1;
        check_output("abort_reset", zero_init);
        check_pc("abort_reset_pc", 7'd0);
        tick();
        reset_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
        $finish;
    end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
Multi-cycle control unit for the 16-bit datapath. It fetches instructions from instruction memory, decodes them, and sequences the ALU (3-bit function select), the register file and data memory, one instruction at a time. It sits above the datapath and drives every ALU select, register-file address/enable and data-memory control line.

Parameters:
PC_W, 7, program counter / instruction-memory address width
DA_W, 8, data-memory address width
RA_W, 4, register-file address width (16 registers)

Ports:
Clk  input  1  system clock, all state updates on rising edge
ResetN  input  1  asynchronous active-low reset
IR_in  input  16  instruction word; combinational read of PC_addr
PC_addr  output  PC_W  instruction-memory address, equal to the PC register
IR_ld  output  1  high in FETCH (debug/trace strobe)
D_addr  output  DA_W  data-memory address
D_wr  output  1  data-memory write enable
RF_s  output  1  register-file write-data mux; 1 = data memory, 0 = ALU result
RF_W_addr  output  RA_W  register-file write address
RF_W_en  output  1  register-file write enable
RF_Ra_addr  output  RA_W  register-file read port A address (to ALU A)
RF_Rb_addr  output  RA_W  register-file read port B address (to ALU B)
ALU_sel  output  3  ALU function select
Halted  output  1  high while in HALT
State  output  4  current state encoding (debug)

Behaviour:
- Reset (ResetN low, asynchronous): state=INIT, PC=0, IR=0. All outputs 0 while in INIT. Reset mid-instruction aborts it; no write strobe may be high in the reset cycle.
- Instruction format: op=IR[15:12].
  - LOAD: op=0010, d=IR[11:4], rd=IR[3:0].
  - STORE: op=0001, ra=IR[11:8], d=IR[7:0].
  - ALU ops: ra=IR[11:8], rb=IR[7:4], rd=IR[3:0].
- Opcode map, with ALU_sel value:
  - 0000 NOOP
  - 0001 STORE
  - 0010 LOAD
  - 0011 ADD, sel 1
  - 0100 SUB, sel 2
  - 0101 MOV (rd=ra), sel 3
  - 0110 XOR, sel 4
  - 0111 OR, sel 5
  - 1000 AND, sel 6
  - 1001 INC (rd=ra+1), sel 7
  - 1010 HALT
  - 1011-1111 illegal; decoded as NOOP.
- Outputs are Moore-decoded from registered state plus IR. Every output not listed for a state is 0.
- States and transitions:
  - INIT -> FETCH (1 cycle).
  - FETCH: PC_addr=PC, IR<=IR_in, PC<=PC+1 (mod 2^PC_W, 127 wraps to 0), IR_ld=1 -> DECODE.
  - DECODE: no strobes. Next state by op: LOAD_A, STORE, ALU_OP, HALT, or NOOP.
  - LOAD_A: D_addr=d, RF_s=1 -> LOAD_B. This is the one-cycle memory read latency.
  - LOAD_B: D_addr=d, RF_s=1, RF_W_addr=rd, RF_W_en=1 -> FETCH.
  - STORE: D_addr=d, RF_Ra_addr=ra, D_wr=1 -> FETCH.
  - ALU_OP: RF_Ra_addr=ra, RF_Rb_addr=rb, ALU_sel=map(op), RF_s=0, RF_W_addr=rd, RF_W_en=1 -> FETCH.
  - NOOP -> FETCH.
  - HALT: Halted=1, holds indefinitely; only ResetN leaves it.
- Instruction latency in cycles, FETCH to next FETCH: NOOP 3, STORE 3, ALU 3, LOAD 4.
- ALU_sel is 0 in all non-ALU_OP states.
- D_wr and RF_W_en are never high in the same cycle.
- rd=ra is legal: the read and write in the same cycle use the old value, and the register-file write lands at the edge.
- PC is not incremented in any state other than FETCH.

Test Plan:
- Reset then release -> INIT for 1 cycle, FETCH next with PC_addr=0. Asserting ResetN low during LOAD_B -> RF_W_en drops to 0 immediately and state=INIT.
- IR_in=0x2_05_3 (LOAD d=0x05 rd=3) -> FETCH, DECODE, LOAD_A with D_addr=0x05 and RF_s=1, LOAD_B with RF_W_en=1 and RF_W_addr=3; PC=1 afterwards.
- IR_in=0x3_1_2_4 (ADD ra=1 rb=2 rd=4) -> ALU_OP cycle with RF_Ra_addr=1, RF_Rb_addr=2, ALU_sel=1, RF_W_addr=4, RF_W_en=1, RF_s=0.
- Sweep op 0011..1001 -> ALU_sel = 1,2,3,4,5,6,7 respectively. Ops 1011..1111 -> NOOP path with no strobes asserted.
- IR_in=0x1_7_20 (STORE ra=7 d=0x20) -> D_wr=1, D_addr=0x20, RF_Ra_addr=7 for exactly 1 cycle, RF_W_en=0.
- PC starting at 127 with NOOP -> PC_addr wraps to 0. IR_in=0xA000 -> Halted=1 and stays high for 20+ cycles with PC unchanged; ResetN low clears Halted.
